wishbone_bus_if: RTL and testbench



---
 rtl/wishbone_bus_if_pkg.sv | 19 +
 rtl/wishbone_bus_if.sv | 136 +++++++++++++
 tb/tb_wishbone_bus_if.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_bus_if_pkg.sv
// Shared definitions for the Wishbone B4 classic master: FSM encodings,
// default widths and the timeout counter width helper.
package wishbone_bus_if_pkg;

   localparam logic [1:0] WB_IDLE           = 2'b00;
   localparam logic [1:0] WB_BUSY           = 2'b01;
   localparam logic [1:0] WB_WAIT_FOR_STALL = 2'b11;

   localparam int WB_DW      = 32;
   localparam int WB_AW      = 32;
   localparam int WB_STALL_W = 6;
   localparam int WB_TIMEOUT = 255;

   // A disabled timeout still needs a 1-bit counter to keep widths legal.
   function automatic int cnt_width(input int timeout);
      return (timeout == 0) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone B4 classic master: turns the core's single-cycle memory port into
// bus cycles, stalling the pipeline while the slave inserts wait states.
module wishbone_bus_if
   import wishbone_bus_if_pkg::*;
#(
   parameter int DW      = WB_DW,
   parameter int AW      = WB_AW,
   parameter int STALL_W = WB_STALL_W,
   parameter int TIMEOUT = WB_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               cpu_ce_i,
   input  logic [AW-1:0]      cpu_addr_i,
   input  logic               cpu_we_i,
   input  logic [DW/8-1:0]    cpu_sel_i,
   input  logic [DW-1:0]      cpu_data_i,
   output logic [DW-1:0]      cpu_data_o,
   output logic               stallreq_o,
   output logic               bus_err_o,
   input  logic [DW-1:0]      wishbone_data_i,
   input  logic               wishbone_ack_i,
   input  logic               wishbone_err_i,
   output logic [AW-1:0]      wishbone_addr_o,
   output logic [DW-1:0]      wishbone_data_o,
   output logic               wishbone_we_o,
   output logic [DW/8-1:0]    wishbone_sel_o,
   output logic               wishbone_stb_o,
   output logic               wishbone_cyc_o
);

   localparam int             CNT_W   = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state;
   logic [DW-1:0]    rd_buf;
   logic [CNT_W-1:0] cnt;

   logic timeout_hit;
   logic busy_flush;
   logic busy_abort;
   logic busy_ack;
   logic bus_end;

   // Priority inside BUSY: flush, then err/timeout, then ack.
   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
   assign busy_flush  = (state == WB_BUSY) && flush_i;
   assign busy_abort  = (state == WB_BUSY) && !flush_i && (wishbone_err_i || timeout_hit);
   assign busy_ack    = (state == WB_BUSY) && !flush_i && !busy_abort && wishbone_ack_i;
   assign bus_end     = busy_flush || busy_abort || busy_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= WB_IDLE;
         rd_buf          <= '0;
         cnt             <= '0;
         wishbone_addr_o <= '0;
         wishbone_data_o <= '0;
         wishbone_we_o   <= 1'b0;
         wishbone_sel_o  <= '0;
         wishbone_stb_o  <= 1'b0;
         wishbone_cyc_o  <= 1'b0;
      end else begin
         // Bus outputs return to zero whenever a transfer ends for any reason.
         if (bus_end) begin
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
         end
         case (state)
            WB_IDLE: begin
               if (cpu_ce_i && !flush_i) begin
                  wishbone_addr_o <= cpu_addr_i;
                  wishbone_data_o <= cpu_data_i;
                  wishbone_we_o   <= cpu_we_i;
                  wishbone_sel_o  <= cpu_sel_i;
                  wishbone_stb_o  <= 1'b1;
                  wishbone_cyc_o  <= 1'b1;
                  cnt             <= '0;
                  rd_buf          <= '0;
                  state           <= WB_BUSY;
               end
            end
            WB_BUSY: begin
               if (busy_flush) begin
                  rd_buf <= '0;
                  state  <= WB_IDLE;
               end else if (busy_abort) begin
                  rd_buf <= '0;
                  state  <= (|stall_i) ? WB_WAIT_FOR_STALL : WB_IDLE;
               end else if (busy_ack) begin
                  if (!wishbone_we_o) rd_buf <= wishbone_data_i;
                  state <= (|stall_i) ? WB_WAIT_FOR_STALL : WB_IDLE;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            WB_WAIT_FOR_STALL: begin
               if (flush_i) begin
                  rd_buf <= '0;
                  state  <= WB_IDLE;
               end else if (stall_i == '0) begin
                  state <= WB_IDLE;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

   always_comb begin
      stallreq_o = 1'b0;
      cpu_data_o = '0;
      bus_err_o  = 1'b0;
      case (state)
         WB_IDLE: stallreq_o = cpu_ce_i && !flush_i;
         WB_BUSY: begin
            if (busy_abort) begin
               bus_err_o = 1'b1;
            end else if (busy_ack) begin
               cpu_data_o = wishbone_we_o ? '0 : wishbone_data_i;
            end else if (!busy_flush) begin
               stallreq_o = 1'b1;
            end
         end
         WB_WAIT_FOR_STALL: cpu_data_o = rd_buf;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if: each task drives one scenario and checks
// stall, data, error and bus outputs against hand-computed values.
module tb_wishbone_bus_if;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  stall_i = '0;
   logic        flush_i = 1'b0;
   logic        cpu_ce_i = 1'b0;
   logic [31:0] cpu_addr_i = '0;
   logic        cpu_we_i = 1'b0;
   logic [3:0]  cpu_sel_i = '0;
   logic [31:0] cpu_data_i = '0;
   logic [31:0] cpu_data_o;
   logic        stallreq_o;
   logic        bus_err_o;
   logic [31:0] wishbone_data_i = '0;
   logic        wishbone_ack_i = 1'b0;
   logic        wishbone_err_i = 1'b0;
   logic [31:0] wishbone_addr_o;
   logic [31:0] wishbone_data_o;
   logic        wishbone_we_o;
   logic [3:0]  wishbone_sel_o;
   logic        wishbone_stb_o;
   logic        wishbone_cyc_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wishbone_bus_if #(.DW(32), .AW(32), .STALL_W(6), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i),
      .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
      .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
      .wishbone_err_i(wishbone_err_i), .wishbone_addr_o(wishbone_addr_o),
      .wishbone_data_o(wishbone_data_o), .wishbone_we_o(wishbone_we_o),
      .wishbone_sel_o(wishbone_sel_o), .wishbone_stb_o(wishbone_stb_o),
      .wishbone_cyc_o(wishbone_cyc_o)
   );

   // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++; if ({wishbone_stb_o, wishbone_cyc_o, wishbone_we_o} !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%b exp=000", {wishbone_stb_o, wishbone_cyc_o, wishbone_we_o}); end
      checks++; if ({wishbone_addr_o, wishbone_data_o, wishbone_sel_o} !== 68'h0) begin failures++; $display("FAIL rst_bus got=%h exp=0", {wishbone_addr_o, wishbone_data_o, wishbone_sel_o}); end
      checks++; if ({stallreq_o, bus_err_o, cpu_data_o} !== 34'h0) begin failures++; $display("FAIL rst_cpu got=%h exp=0", {stallreq_o, bus_err_o, cpu_data_o}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_zero_wait_read();
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h100; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      @(negedge clk);
      checks++; if (stallreq_o !== 1'b1) begin failures++; $display("FAIL zw_stall_idle got=%b exp=1", stallreq_o); end
      tick();
      wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if ({wishbone_stb_o, wishbone_cyc_o, wishbone_addr_o} !== {2'b11, 32'h100}) begin failures++; $display("FAIL zw_bus got=%h exp=%h", {wishbone_stb_o, wishbone_cyc_o, wishbone_addr_o}, {2'b11, 32'h100}); end
      checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL zw_stall_ack got=%b exp=0", stallreq_o); end
      checks++; if (cpu_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL zw_data got=%h exp=deadbeef", cpu_data_o); end
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0; cpu_ce_i = 1'b0;
      @(negedge clk);
      checks++; if ({wishbone_stb_o, wishbone_cyc_o, stallreq_o, cpu_data_o} !== 35'h0) begin failures++; $display("FAIL zw_idle got=%h exp=0", {wishbone_stb_o, wishbone_cyc_o, stallreq_o, cpu_data_o}); end
   endtask

   task automatic test_wait_write();
      int n_stall;
      logic [69:0] exp_bus;
      exp_bus = {32'h200, 32'h12345678, 1'b1, 4'b0011, 1'b1};
      n_stall = 0;
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h200; cpu_we_i = 1'b1; cpu_sel_i = 4'b0011; cpu_data_i = 32'h12345678;
      @(negedge clk);
      if (stallreq_o) n_stall++;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         if (stallreq_o) n_stall++;
         checks++; if ({wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o, wishbone_stb_o} !== exp_bus || wishbone_cyc_o !== 1'b1) begin failures++; $display("FAIL ww_stable%0d got=%h exp=%h", i, {wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o, wishbone_stb_o}, exp_bus); end
      end
      tick();
      wishbone_ack_i = 1'b1; wishbone_data_i = 32'h99999999;
      @(negedge clk);
      if (stallreq_o) n_stall++;
      checks++; if (cpu_data_o !== 32'h0) begin failures++; $display("FAIL ww_data got=%h exp=0", cpu_data_o); end
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
      @(negedge clk);
      checks++; if ({wishbone_stb_o, wishbone_cyc_o, wishbone_we_o, wishbone_sel_o} !== 7'h0) begin failures++; $display("FAIL ww_end got=%h exp=0", {wishbone_stb_o, wishbone_cyc_o, wishbone_we_o, wishbone_sel_o}); end
      checks++; if (n_stall !== 4) begin failures++; $display("FAIL ww_stall_cycles got=%0d exp=4", n_stall); end
   endtask

   task automatic test_read_stall();
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h400; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      tick();
      wishbone_ack_i = 1'b1; wishbone_data_i = 32'hA5A5A5A5; stall_i = 6'b000011;
      @(negedge clk);
      checks++; if ({stallreq_o, cpu_data_o} !== {1'b0, 32'hA5A5A5A5}) begin failures++; $display("FAIL rs_ack got=%h exp=%h", {stallreq_o, cpu_data_o}, {1'b0, 32'hA5A5A5A5}); end
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0; cpu_ce_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({stallreq_o, cpu_data_o} !== {1'b0, 32'hA5A5A5A5}) begin failures++; $display("FAIL rs_hold%0d got=%h exp=%h", i, {stallreq_o, cpu_data_o}, {1'b0, 32'hA5A5A5A5}); end
         tick();
      end
      stall_i = '0;
      @(negedge clk);
      checks++; if (cpu_data_o !== 32'hA5A5A5A5) begin failures++; $display("FAIL rs_last got=%h exp=a5a5a5a5", cpu_data_o); end
      tick();
      @(negedge clk);
      checks++; if (cpu_data_o !== 32'h0) begin failures++; $display("FAIL rs_idle got=%h exp=0", cpu_data_o); end
   endtask

   task automatic test_flush();
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h500; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      tick();
      @(negedge clk);
      checks++; if (stallreq_o !== 1'b1) begin failures++; $display("FAIL fl_wait1 got=%b exp=1", stallreq_o); end
      tick();
      flush_i = 1'b1;
      @(negedge clk);
      checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL fl_err got=%b exp=0", bus_err_o); end
      tick();
      flush_i = 1'b0; cpu_ce_i = 1'b0;
      @(negedge clk);
      checks++; if ({wishbone_stb_o, wishbone_cyc_o} !== 2'b00) begin failures++; $display("FAIL fl_drop got=%b exp=00", {wishbone_stb_o, wishbone_cyc_o}); end
      wishbone_ack_i = 1'b1; wishbone_data_i = 32'h11111111;
      #1;
      checks++; if ({bus_err_o, stallreq_o, cpu_data_o} !== 34'h0) begin failures++; $display("FAIL fl_stray got=%h exp=0", {bus_err_o, stallreq_o, cpu_data_o}); end
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0;
      @(negedge clk);
      checks++; if ({wishbone_stb_o, wishbone_cyc_o, cpu_data_o} !== 34'h0) begin failures++; $display("FAIL fl_after got=%h exp=0", {wishbone_stb_o, wishbone_cyc_o, cpu_data_o}); end
   endtask

   task automatic test_timeout();
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h600; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      wishbone_data_i = 32'hCAFEF00D;
      for (int i = 1; i <= 4; i++) begin
         tick();
         @(negedge clk);
         if (i < 4) begin
            checks++; if ({bus_err_o, stallreq_o} !== 2'b01) begin failures++; $display("FAIL to_wait%0d got=%b exp=01", i, {bus_err_o, stallreq_o}); end
         end else begin
            checks++; if ({bus_err_o, stallreq_o, cpu_data_o} !== {2'b10, 32'h0}) begin failures++; $display("FAIL to_abort got=%h exp=%h", {bus_err_o, stallreq_o, cpu_data_o}, {2'b10, 32'h0}); end
         end
      end
      tick();
      cpu_ce_i = 1'b0; wishbone_data_i = '0;
      @(negedge clk);
      checks++; if ({bus_err_o, wishbone_cyc_o, wishbone_stb_o} !== 3'b000) begin failures++; $display("FAIL to_end got=%b exp=000", {bus_err_o, wishbone_cyc_o, wishbone_stb_o}); end
   endtask

   task automatic test_slave_err();
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h700; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      tick();
      wishbone_err_i = 1'b1; wishbone_data_i = 32'hFFFFFFFF;
      @(negedge clk);
      checks++; if ({bus_err_o, stallreq_o, cpu_data_o} !== {2'b10, 32'h0}) begin failures++; $display("FAIL se_abort got=%h exp=%h", {bus_err_o, stallreq_o, cpu_data_o}, {2'b10, 32'h0}); end
      tick();
      wishbone_err_i = 1'b0; wishbone_data_i = '0; cpu_ce_i = 1'b0;
      @(negedge clk);
      checks++; if ({bus_err_o, wishbone_cyc_o} !== 2'b00) begin failures++; $display("FAIL se_end got=%b exp=00", {bus_err_o, wishbone_cyc_o}); end
   endtask

   task automatic test_back_to_back();
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h800; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
      tick();
      wishbone_ack_i = 1'b1; wishbone_data_i = 32'h01010101;
      @(negedge clk);
      checks++; if (cpu_data_o !== 32'h01010101) begin failures++; $display("FAIL bb_data1 got=%h exp=01010101", cpu_data_o); end
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0; cpu_addr_i = 32'h804;
      @(negedge clk);
      checks++; if ({wishbone_stb_o, stallreq_o} !== 2'b01) begin failures++; $display("FAIL bb_gap got=%b exp=01", {wishbone_stb_o, stallreq_o}); end
      tick();
      wishbone_ack_i = 1'b1; wishbone_data_i = 32'h02020202;
      @(negedge clk);
      checks++; if ({wishbone_stb_o, wishbone_addr_o, cpu_data_o} !== {1'b1, 32'h804, 32'h02020202}) begin failures++; $display("FAIL bb_second got=%h exp=%h", {wishbone_stb_o, wishbone_addr_o, cpu_data_o}, {1'b1, 32'h804, 32'h02020202}); end
      tick();
      wishbone_ack_i = 1'b0; wishbone_data_i = '0; cpu_ce_i = 1'b0;
      @(negedge clk);
      checks++; if (wishbone_stb_o !== 1'b0) begin failures++; $display("FAIL bb_end got=%b exp=0", wishbone_stb_o); end
   endtask

   task automatic test_reset_busy();
      tick();
      cpu_ce_i = 1'b1; cpu_addr_i = 32'h900; cpu_we_i = 1'b1; cpu_sel_i = 4'hF; cpu_data_i = 32'h55;
      tick();
      @(negedge clk);
      checks++; if ({wishbone_stb_o, wishbone_cyc_o} !== 2'b11) begin failures++; $display("FAIL rb_busy got=%b exp=11", {wishbone_stb_o, wishbone_cyc_o}); end
      #2;
      rst = 1'b0; cpu_ce_i = 1'b0;
      #1;
      checks++; if ({wishbone_stb_o, wishbone_cyc_o, wishbone_we_o, wishbone_sel_o} !== 7'h0) begin failures++; $display("FAIL rb_ctrl got=%h exp=0", {wishbone_stb_o, wishbone_cyc_o, wishbone_we_o, wishbone_sel_o}); end
      checks++; if ({wishbone_addr_o, wishbone_data_o} !== 64'h0) begin failures++; $display("FAIL rb_bus got=%h exp=0", {wishbone_addr_o, wishbone_data_o}); end
      checks++; if ({stallreq_o, bus_err_o, cpu_data_o} !== 34'h0) begin failures++; $display("FAIL rb_cpu got=%h exp=0", {stallreq_o, bus_err_o, cpu_data_o}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_zero_wait_read();
      test_wait_write();
      test_read_stall();
      test_flush();
      test_timeout();
      test_slave_err();
      test_back_to_back();
      test_reset_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
